// File: rtl/fir_pkg.sv
// Shared types for the block-floating-point normalizer: exponent width/type and defaults.
// EXP_W matches the shift port of the downstream arithmetic right-shifter.
package fir_pkg;
    localparam int EXP_W          = 5;
    localparam int DATA_W_DEFAULT = 16;

    typedef logic [EXP_W-1:0] exp_t;

    localparam exp_t EXP_MAX = '1;

    function automatic exp_t exp_min(input exp_t a, input exp_t b);
        return (a < b) ? a : b;
    endfunction
endpackage

// File: rtl/lsb_count.sv
// Redundant-sign-bit counter: number of bits below the MSB that equal the sign bit.
// Purely combinational; result ranges 0..DATA_W-1.
module lsb_count
    import fir_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic [DATA_W-1:0] data_i,
    output exp_t              count_o
);

    logic run;

    always_comb begin
        count_o = '0;
        run     = 1'b1;
        for (int i = DATA_W - 2; i >= 0; i--) begin
            if (run && (data_i[i] == data_i[DATA_W-1])) begin
                count_o = count_o + exp_t'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fir_normalizer.sv
// Two-stage sample normalizer with valid/ready handshake and per-frame block exponent.
// Stage 1 holds the sample and its clamped exponent; stage 2 holds the shifted mantissa.
module fir_normalizer
    import fir_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int MAX_SHIFT = 15,
    parameter int FRAME_LEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  frame_exp,
    output logic              frame_done
);

    localparam int                CNT_W       = $clog2(FRAME_LEN);
    localparam exp_t              SHIFT_CLAMP = exp_t'(MAX_SHIFT);
    localparam logic [CNT_W-1:0]  LAST_IDX    = CNT_W'(FRAME_LEN - 1);

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;
    exp_t              s1_exp_q;
    exp_t              s1_exp_d;
    exp_t              rsb_cnt;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_mant_q;
    exp_t              out_exp_q;

    logic [CNT_W-1:0]  frame_cnt_q;
    logic [CNT_W-1:0]  frame_cnt_d;
    exp_t              run_min_q;
    exp_t              run_min_d;
    exp_t              frame_exp_q;
    logic              frame_done_q;

    logic s2_free;
    logic s1_free;
    logic in_xfer;
    logic out_xfer;

    lsb_count #(.DATA_W(DATA_W)) u_lsb_count (
        .data_i  (in_data),
        .count_o (rsb_cnt)
    );

    assign s1_exp_d = (rsb_cnt > SHIFT_CLAMP) ? SHIFT_CLAMP : rsb_cnt;

    // Ready depends only on registered state and out_ready, never on in_valid.
    assign s2_free  = ~out_valid_q | out_ready;
    assign s1_free  = ~s1_valid_q | s2_free;
    assign in_ready = rst_n & s1_free;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid_q & out_ready;

    assign frame_cnt_d = (frame_cnt_q == LAST_IDX) ? '0 : frame_cnt_q + CNT_W'(1);
    assign run_min_d   = exp_min(run_min_q, out_exp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_exp_q   <= '0;
        end else if (s1_free) begin
            s1_valid_q <= in_valid;
            if (in_xfer) begin
                s1_data_q <= in_data;
                s1_exp_q  <= s1_exp_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_mant_q  <= '0;
            out_exp_q   <= '0;
        end else if (s2_free) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_mant_q <= s1_data_q << s1_exp_q;
                out_exp_q  <= s1_exp_q;
            end
        end
    end

    // Frame bookkeeping advances only on output transfers, so stalls never double-count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q  <= '0;
            run_min_q    <= EXP_MAX;
            frame_exp_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (out_xfer) begin
                frame_cnt_q <= frame_cnt_d;
                if (frame_cnt_q == LAST_IDX) begin
                    frame_exp_q  <= run_min_d;
                    frame_done_q <= 1'b1;
                    run_min_q    <= EXP_MAX;
                end else begin
                    run_min_q <= run_min_d;
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_mant   = out_mant_q;
    assign out_exp    = out_exp_q;
    assign frame_exp  = frame_exp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fir_normalizer.sv
// Self-checking bench for fir_normalizer: scoreboarded output stream plus scenario tasks.
// Main instance uses FRAME_LEN=4; a second instance exercises MAX_SHIFT=4.
module tb_fir_normalizer;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_mant;
    logic [4:0]  out_exp;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  frame_exp;
    logic        frame_done;

    logic [15:0] in2_data;
    logic        in2_valid;
    logic        in2_ready;
    logic [15:0] out2_mant;
    logic [4:0]  out2_exp;
    logic        out2_valid;
    logic        out2_ready;
    logic [4:0]  frame2_exp;
    logic        frame2_done;

    int vectors;
    int miscompares;
    int out_count;
    int pulse_count;
    logic [20:0] sb_q[$];

    fir_normalizer #(.DATA_W(16), .MAX_SHIFT(15), .FRAME_LEN(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_mant   (out_mant),
        .out_exp    (out_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_exp  (frame_exp),
        .frame_done (frame_done)
    );

    fir_normalizer #(.DATA_W(16), .MAX_SHIFT(4), .FRAME_LEN(64)) dut_ms (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in2_data),
        .in_valid   (in2_valid),
        .in_ready   (in2_ready),
        .out_mant   (out2_mant),
        .out_exp    (out2_exp),
        .out_valid  (out2_valid),
        .out_ready  (out2_ready),
        .frame_exp  (frame2_exp),
        .frame_done (frame2_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: largest shift (<= maxs) that survives a round trip through an arithmetic right shift.
    function automatic logic [20:0] model(input logic [15:0] x, input int maxs);
        logic signed [15:0] xs;
        logic signed [15:0] y;
        int   e;
        logic ok;
        xs = x;
        e  = 0;
        ok = 1'b1;
        for (int s = 1; s <= 15; s++) begin
            y = xs <<< s;
            if (ok && (s <= maxs) && ((y >>> s) == xs)) e = s;
            else ok = 1'b0;
        end
        return {x << e, 5'(e)};
    endfunction

    task automatic monitor();
        logic [20:0] exp_v;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (in_valid && in_ready) sb_q.push_back(model(in_data, 15));
                if (out_valid && out_ready) begin
                    out_count++;
                    vectors++;
                    if (sb_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL sb_unexpected: got mant=%h exp=%0d, expected no output", out_mant, out_exp);
                    end else begin
                        exp_v = sb_q.pop_front();
                        if ({out_mant, out_exp} !== exp_v) begin
                            miscompares++;
                            $display("FAIL sb_output: got mant=%h exp=%0d, expected mant=%h exp=%0d",
                                     out_mant, out_exp, exp_v[20:5], exp_v[4:0]);
                        end
                    end
                end
                if (frame_done) pulse_count++;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the transfer edge.
    task automatic send(input logic [15:0] d);
        int n;
        n        = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready=%b, expected 1 within 100 cycles", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        vectors += 6;
        if (out_valid !== 1'b0)   begin miscompares++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
        if (in_ready !== 1'b0)    begin miscompares++; $display("FAIL rst_in_ready: got %b, expected 0", in_ready); end
        if (out_mant !== 16'h0)   begin miscompares++; $display("FAIL rst_out_mant: got %h, expected 0000", out_mant); end
        if (out_exp !== 5'd0)     begin miscompares++; $display("FAIL rst_out_exp: got %0d, expected 0", out_exp); end
        if (frame_exp !== 5'd0)   begin miscompares++; $display("FAIL rst_frame_exp: got %0d, expected 0", frame_exp); end
        if (frame_done !== 1'b0)  begin miscompares++; $display("FAIL rst_frame_done: got %b, expected 0", frame_done); end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b, expected 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        send(16'h0001);
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_early: out_valid=%b, expected 0", out_valid); end
        @(posedge clk);
        #1;
        vectors += 3;
        if (out_valid !== 1'b1)  begin miscompares++; $display("FAIL single_valid: got %b, expected 1", out_valid); end
        if (out_mant !== 16'h4000) begin miscompares++; $display("FAIL single_mant: got %h, expected 4000", out_mant); end
        if (out_exp !== 5'd14)   begin miscompares++; $display("FAIL single_exp: got %0d, expected 14", out_exp); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] din [4]  = '{16'hFFFF, 16'h0000, 16'h8000, 16'hC000};
        logic [15:0] em  [4]  = '{16'h8000, 16'h0000, 16'h8000, 16'h8000};
        logic [4:0]  ee  [4]  = '{5'd15, 5'd15, 5'd0, 5'd1};
        fork
            begin
                for (int i = 0; i < 4; i++) send(din[i]);
                in_valid = 1'b0;
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 4; i++) begin
                    vectors += 3;
                    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_gap[%0d]: out_valid=%b, expected 1", i, out_valid); end
                    if (out_mant !== em[i]) begin miscompares++; $display("FAIL b2b_mant[%0d]: got %h, expected %h", i, out_mant, em[i]); end
                    if (out_exp !== ee[i])  begin miscompares++; $display("FAIL b2b_exp[%0d]: got %0d, expected %0d", i, out_exp, ee[i]); end
                    if (i < 3) @(negedge clk);
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_frame();
        logic [15:0] din [4] = '{16'h0800, 16'h0080, 16'h1000, 16'h0020};
        int p0;
        do_reset();
        @(posedge clk);
        #1;
        p0 = pulse_count;
        for (int i = 0; i < 4; i++) send(din[i]);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        vectors += 2;
        if (pulse_count - p0 !== 1) begin miscompares++; $display("FAIL frame_pulses: got %0d, expected 1", pulse_count - p0); end
        if (frame_exp !== 5'd2)     begin miscompares++; $display("FAIL frame_exp: got %0d, expected 2", frame_exp); end
    endtask

    task automatic test_stall();
        logic [15:0] din [8] = '{16'h0800, 16'h0080, 16'h1000, 16'h0020, 16'hFFF0, 16'h0100, 16'h4000, 16'hE000};
        int p0;
        int c0;
        do_reset();
        @(posedge clk);
        #1;
        p0 = pulse_count;
        c0 = out_count;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) send(din[i]);
                in_valid = 1'b0;
            end
            begin
                int n;
                logic [15:0] hm;
                logic [4:0]  he;
                n = 0;
                while (out_count != c0 + 3 && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                out_ready = 1'b0;
                @(negedge clk);
                hm = out_mant;
                he = out_exp;
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    vectors += 4;
                    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b, expected 1", k, out_valid); end
                    if (out_mant !== hm)    begin miscompares++; $display("FAIL stall_mant[%0d]: got %h, expected %h", k, out_mant, hm); end
                    if (out_exp !== he)     begin miscompares++; $display("FAIL stall_exp[%0d]: got %0d, expected %0d", k, out_exp, he); end
                    if (in_ready !== 1'b0)  begin miscompares++; $display("FAIL stall_in_ready[%0d]: got %b, expected 0", k, in_ready); end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        vectors += 3;
        if (out_count - c0 !== 8)   begin miscompares++; $display("FAIL stall_count: got %0d outputs, expected 8", out_count - c0); end
        if (pulse_count - p0 !== 2) begin miscompares++; $display("FAIL stall_pulses: got %0d, expected 2", pulse_count - p0); end
        if (sb_q.size() !== 0)      begin miscompares++; $display("FAIL stall_leftover: got %0d queued, expected 0", sb_q.size()); end
    endtask

    task automatic test_reset_midflight();
        int c0;
        out_ready = 1'b0;
        send(16'h0003);
        send(16'h0700);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        vectors += 2;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b, expected 0", out_valid); end
        if (in_ready !== 1'b0)  begin miscompares++; $display("FAIL mid_rst_ready: got %b, expected 0", in_ready); end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        c0        = out_count;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_stale[%0d]: out_valid=%b, expected 0", k, out_valid); end
        end
        @(posedge clk);
        #1;
        send(16'h00F0);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (out_count - c0 !== 1) begin miscompares++; $display("FAIL mid_rst_after: got %0d outputs, expected 1", out_count - c0); end
    endtask

    task automatic test_max_shift();
        logic [15:0] din [3] = '{16'h0003, 16'h0000, 16'h7FFF};
        logic [15:0] em  [3] = '{16'h0030, 16'h0000, 16'h7FFF};
        logic [4:0]  ee  [3] = '{5'd4, 5'd4, 5'd0};
        for (int i = 0; i < 3; i++) begin
            in2_data  = din[i];
            in2_valid = 1'b1;
            vectors++;
            if (in2_ready !== 1'b1) begin miscompares++; $display("FAIL ms_ready[%0d]: got %b, expected 1", i, in2_ready); end
            @(posedge clk);
            #1;
            in2_valid = 1'b0;
            @(posedge clk);
            #1;
            vectors += 3;
            if (out2_valid !== 1'b1) begin miscompares++; $display("FAIL ms_valid[%0d]: got %b, expected 1", i, out2_valid); end
            if (out2_mant !== em[i]) begin miscompares++; $display("FAIL ms_mant[%0d]: got %h, expected %h", i, out2_mant, em[i]); end
            if (out2_exp !== ee[i])  begin miscompares++; $display("FAIL ms_exp[%0d]: got %0d, expected %0d", i, out2_exp, ee[i]); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        logic took;
        logic [15:0] corner [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
        took = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!in_valid || took) begin
                in_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 4) == 0) in_data = corner[$urandom_range(0, 3)];
                else in_data = 16'($urandom) >> $urandom_range(0, 15);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (sb_q.size() !== 0) begin miscompares++; $display("FAIL rand_leftover: got %0d queued, expected 0", sb_q.size()); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        out_count   = 0;
        pulse_count = 0;
        rst_n       = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        in2_data    = '0;
        in2_valid   = 1'b0;
        out2_ready  = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_back_to_back();
        test_frame();
        test_stall();
        test_reset_midflight();
        test_max_shift();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fir_normalizer.md
FIR_NORMALIZER -- requirements
Module: fir_normalizer

Interface
REQ-001 Parameter DATA_W, default 16, sample and mantissa width in bits.
REQ-002 Parameter MAX_SHIFT, default 15, upper clamp on the reported exponent, range 0..DATA_W-1.
REQ-003 Parameter FRAME_LEN, default 64, samples per block-exponent frame, at least 2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_data  input  DATA_W  two's-complement sample.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 out_mant  output  DATA_W  normalized sample (in_data shifted left by out_exp).
REQ-010 out_exp  output  5  left-shift applied; unsigned 0..MAX_SHIFT; restores the original when used as a right-shift amount with arithmetic mode.
REQ-011 out_valid  output  1  out_mant and out_exp are valid.
REQ-012 out_ready  input  1  downstream accepts the output this cycle.
REQ-013 frame_exp  output  5  minimum out_exp over the last completed frame.
REQ-014 frame_done  output  1  one-cycle pulse when frame_exp updates.

Function
REQ-015 Transfer occurs on a port when valid and ready are both 1 on a rising edge; valid and data are held stable until transfer.
REQ-016 Two-stage pipeline: stage 1 registers the sample and its redundant-sign-bit count; stage 2 registers the shifted mantissa and the exponent.
REQ-017 Latency from input transfer to out_valid is exactly 2 cycles with no stall.
REQ-018 Throughput is one sample per cycle while out_ready is 1.
REQ-019 in_ready equals out_ready, or stage 1 empty, or stage 2 empty; no combinational path exists from in_valid to in_ready.
REQ-020 A stalled stage holds its contents; a sample is never dropped or duplicated.
REQ-021 The exponent is the count of leading bits equal to the sign bit, minus 1, clamped to MAX_SHIFT.
REQ-022 out_mant is the input shifted left by out_exp, with zero fill and truncation to DATA_W bits.
REQ-023 Boundary values: input 0 gives exp = MAX_SHIFT and mant 0; input all-ones gives exp 15 and mant 0x8000 at the default MAX_SHIFT; input 0x8000 or 0x7FFF gives exp 0.
REQ-024 The frame counter increments on each output transfer, wraps at FRAME_LEN-1 to 0, and tracks the running minimum exponent.
REQ-025 On the last sample of a frame: frame_exp is set to min(running minimum, this exp), frame_done pulses for 1 cycle, and the running minimum resets to 31.
REQ-026 When a frame's last transfer coincides with a stall release, the pulse still occurs exactly once.

Reset
REQ-027 While rst_n is 0: out_valid = 0, stage valids = 0, out_mant = 0, out_exp = 0, frame_exp = 0, frame_done = 0, frame counter = 0, running minimum = 31.
REQ-028 in_ready is 0 while rst_n is 0 and is 1 in the first cycle after release.
REQ-029 Reset asserted mid-operation discards all in-flight samples and the partial frame.

Structure
REQ-030 Shared package fir_pkg holds EXP_W = 5, the exponent type, and the DATA_W default; the 5-bit exponent matches the shift port of the existing right-shifter.
REQ-031 The redundant-sign-bit counter is one combinational sub-module, lsb_count, with DATA_W in and EXP_W out; all remaining logic is in fir_normalizer.

Verification
REQ-032 Reset, then in_data = 0x0001 with valid for 1 cycle -> out_valid 2 cycles later, out_mant = 0x4000, out_exp = 14.
REQ-033 Stream 0xFFFF, 0x0000, 0x8000, 0xC000 back-to-back -> (0x8000,15), (0x0000,15), (0x8000,0), (0x8000,1) in order with no gaps.
REQ-034 Hold out_ready = 0 for 5 cycles mid-stream -> in_ready = 0 after 2 samples are queued, outputs held stable, no loss after out_ready returns to 1.
REQ-035 FRAME_LEN = 4, exps 3, 7, 2, 9 -> frame_done pulses once on the 4th output transfer with frame_exp = 2.
REQ-036 MAX_SHIFT = 4, input 0x0003 -> out_exp = 4, out_mant = 0x0030.
REQ-037 Assert rst_n = 0 with 2 samples in flight -> out_valid = 0 immediately; no stale output after release.
